ltc2308_responder: RTL and testbench

- Synthesizable responder model of the LTC2308 8-channel, 12-bit SPI ADC. It is the device end of the link driven by our ADC scan controller.
- Used in on-board loopback and in simulation, so the scan controller can be exercised without the physical ADC.
- Channel values come from fabric inputs. The block decodes the 6-bit config word on SDI, emulates conversion time, and returns the pipelined 12-bit result on SDO.

---
 rtl/ltc2308_responder_pkg.sv | 45 ++++
 rtl/ltc2308_responder_if.sv | 25 ++
 rtl/ltc2308_responder_edge_sync.sv | 38 +++
 rtl/ltc2308_responder.sv | 152 +++++++++++++++
 tb/tb_ltc2308_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ltc2308_responder_pkg.sv
// Shared types and constants for the LTC2308 responder model.
//   state_t      : responder frame state
//   CFG_*        : bit positions inside the 6-bit config word {S/D, O/S, S1, S0, UNI, SLP}
//   cfg_result() : selects and formats the channel value a config word asks for
package adc_pkg;

    localparam int unsigned ADC_BITS = 12;
    localparam int unsigned CFG_BITS = 6;
    localparam int unsigned NUM_CH   = 8;

    localparam logic [CFG_BITS-1:0] CFG_RESET = 6'b100010;

    localparam int unsigned CFG_SD  = 5;
    localparam int unsigned CFG_OS  = 4;
    localparam int unsigned CFG_S1  = 3;
    localparam int unsigned CFG_S0  = 2;
    localparam int unsigned CFG_UNI = 1;
    localparam int unsigned CFG_SLP = 0;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READY,
        SHIFT
    } state_t;

    // Differential mode is not modelled and returns zero; bipolar mode
    // flips the MSB to turn offset binary into two's complement.
    function automatic logic [ADC_BITS-1:0] cfg_result(
        input logic [CFG_BITS-1:0]        cfg,
        input logic [NUM_CH*ADC_BITS-1:0] data
    );
        logic [2:0]          ch;
        logic [ADC_BITS-1:0] val;
        ch  = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
        val = data[ch*ADC_BITS +: ADC_BITS];
        if (!cfg[CFG_SD]) begin
            val = '0;
        end else if (!cfg[CFG_UNI]) begin
            val = val ^ 12'h800;
        end
        return val;
    endfunction

endpackage

// File: rtl/ltc2308_responder_if.sv
// SPI link between the ADC scan controller (master) and the responder (slave).
//   ADC_CONVST : conversion start, driven by master
//   ADC_SCK    : serial clock, driven by master
//   ADC_SDI    : config word MSB first, driven by master
//   ADC_SDO    : conversion result MSB first, driven by slave
interface ltc2308_responder_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (
        output ADC_CONVST,
        output ADC_SCK,
        output ADC_SDI,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CONVST,
        input  ADC_SCK,
        input  ADC_SDI,
        output ADC_SDO
    );
endinterface

// File: rtl/ltc2308_responder_edge_sync.sv
// Multi-flop synchronizer with edge strobes.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   level    : synchronized level (STAGES clk behind d)
//   rise     : one-clk strobe on a synchronized 0->1 transition
//   fall     : one-clk strobe on a synchronized 1->0 transition
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ltc2308_responder.sv
// Device-side model of the LTC2308 8-channel 12-bit SPI ADC.
//   clk, rst  : system clock (>= 8x SCK), asynchronous active-high reset
//   adc       : SPI link (slave modport): CONVST, SCK, SDI in; SDO out
//   ch_data   : eight 12-bit channel values, ch n at [12n+11:12n]
//   busy      : high while a conversion is running
//   cfg_word  : last complete 6-bit config word captured
//   proto_err : one-clk pulse on any protocol violation
module ltc2308_responder
    import adc_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    ltc2308_responder_if.slave          adc,
    input  logic [NUM_CH*ADC_BITS-1:0]  ch_data,
    output logic                        busy,
    output logic [CFG_BITS-1:0]         cfg_word,
    output logic                        proto_err
);

    localparam int unsigned TW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    logic cv_rise, cv_fall, sck_rise, sck_fall, sdi_level;
    logic unused_cv_level, unused_sck_level, unused_sdi_rise, unused_sdi_fall;

    state_t state_q, state_d;

    logic [ADC_BITS-1:0] conv_reg;
    logic [ADC_BITS-1:0] out_sr;
    logic [CFG_BITS-1:0] in_sr;
    logic [CFG_BITS-1:0] in_next;
    logic [2:0]          in_cnt;
    logic [3:0]          bit_cnt;
    logic [TW-1:0]       timer;
    logic                start_conv;
    logic                err_d;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_convst (
        .clk   (clk),
        .rst   (rst),
        .d     (adc.ADC_CONVST),
        .level (unused_cv_level),
        .rise  (cv_rise),
        .fall  (cv_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .d     (adc.ADC_SCK),
        .level (unused_sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk   (clk),
        .rst   (rst),
        .d     (adc.ADC_SDI),
        .level (sdi_level),
        .rise  (unused_sdi_rise),
        .fall  (unused_sdi_fall)
    );

    // CONVST rise starts a conversion from every state except CONVERT.
    assign start_conv = cv_rise && (state_q != CONVERT);
    assign in_next    = {in_sr[CFG_BITS-2:0], sdi_level};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cv_rise) state_d = CONVERT;
            CONVERT: if (timer == '0) state_d = READY;
            READY: begin
                if (cv_rise)      state_d = CONVERT;
                else if (cv_fall) state_d = SHIFT;
            end
            SHIFT:   if (cv_rise) state_d = CONVERT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == CONVERT);
        adc.ADC_SDO = (state_q == SHIFT) && (bit_cnt < 4'(ADC_BITS)) && out_sr[ADC_BITS-1];
        err_d       = (cv_rise && (state_q == CONVERT || state_q == READY))
                   || (start_conv && !cfg_word[CFG_SD])
                   || ((state_q != SHIFT) && (sck_rise || sck_fall));
    end

    // cfg_word doubles as the active config: both are loaded from the same
    // completed shift and both reset to CFG_RESET, so one register serves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_reg  <= '0;
            out_sr    <= '0;
            in_sr     <= '0;
            in_cnt    <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            cfg_word  <= CFG_RESET;
            proto_err <= 1'b0;
        end else begin
            proto_err <= err_d;
            if (start_conv) begin
                conv_reg <= cfg_result(cfg_word, ch_data);
                timer    <= TW'(CONV_CYCLES - 1);
            end else begin
                case (state_q)
                    CONVERT: begin
                        if (timer == '0) begin
                            out_sr <= conv_reg;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    READY: begin
                        if (cv_fall) begin
                            bit_cnt <= '0;
                            in_cnt  <= '0;
                        end
                    end
                    SHIFT: begin
                        if (sck_rise && in_cnt < 3'(CFG_BITS)) begin
                            in_sr  <= in_next;
                            in_cnt <= in_cnt + 1'b1;
                            if (in_cnt == 3'(CFG_BITS - 1)) begin
                                cfg_word <= in_next;
                            end
                        end
                        if (sck_fall && bit_cnt < 4'(ADC_BITS)) begin
                            out_sr  <= {out_sr[ADC_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed bench for ltc2308_responder with a result scoreboard.
module tb_ltc2308_responder;
    import adc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] ch_data;
    logic        busy;
    logic [5:0]  cfg_word;
    logic        proto_err;

    ltc2308_responder_if bus ();

    ltc2308_responder #(.CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .adc       (bus.slave),
        .ch_data   (ch_data),
        .busy      (busy),
        .cfg_word  (cfg_word),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int e0;
    logic [11:0] exp_q[$];
    logic [5:0]  model_cfg;

    always @(negedge clk) begin
        if (proto_err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model written from the datasheet-level description.
    function automatic logic [11:0] model(input logic [5:0] cfg, input logic [95:0] d);
        int unsigned ch;
        logic [11:0] v;
        ch = 0;
        if (cfg[3]) ch += 4;
        if (cfg[2]) ch += 2;
        if (cfg[4]) ch += 1;
        v = d[ch*12 +: 12];
        if (cfg[5] == 1'b0) return 12'h000;
        if (cfg[1] == 1'b0) v[11] = ~v[11];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic conv_start();
        exp_q.push_back(model(model_cfg, ch_data));
        busy_cnt = 0;
        bus.ADC_CONVST = 1'b1;
    endtask

    task automatic finish_conv();
        tick(74);
        bus.ADC_CONVST = 1'b0;
    endtask

    task automatic shift(input logic [5:0] cfg, input int n, input string tag);
        logic [11:0] got;
        logic [11:0] exp;
        got = '0;
        for (int i = 0; i < n; i++) begin
            bus.ADC_SDI = (i < 6) ? cfg[5-i] : 1'b0;
            tick(6);
            if (i < 12) got = {got[10:0], bus.ADC_SDO};
            else check({tag, "_extra_sdo"}, 32'(bus.ADC_SDO), 32'h0);
            bus.ADC_SCK = 1'b1;
            tick(6);
            bus.ADC_SCK = 1'b0;
        end
        bus.ADC_SDI = 1'b0;
        tick(6);
        if (n >= 6) model_cfg = cfg;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed no pending result expected one", tag);
        end else begin
            exp = exp_q.pop_front();
            if (n >= 12) check(tag, 32'(got), 32'(exp));
            else check(tag, 32'(got), 32'(exp >> (12 - n)));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ADC_CONVST = 1'b0;
        bus.ADC_SCK = 1'b0;
        bus.ADC_SDI = 1'b0;
        ch_data = '0;
        ch_data[0*12 +: 12] = 12'hA5C;
        ch_data[3*12 +: 12] = 12'h123;
        ch_data[5*12 +: 12] = 12'h000;
        model_cfg = 6'b100010;
        tick(3);
        rst = 1'b0;
        tick(3);
        check("rst_sdo", 32'(bus.ADC_SDO), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(proto_err), 32'h0);
        check("rst_cfg", 32'(cfg_word), 32'h22);

        // SCK edges in IDLE: one error pulse per edge
        e0 = err_cnt;
        bus.ADC_SCK = 1'b1;
        tick(6);
        bus.ADC_SCK = 1'b0;
        tick(6);
        check("idle_sck_err", 32'(err_cnt - e0), 32'd2);
        check("idle_busy", 32'(busy), 32'h0);

        // F1: reset config, ch0
        e0 = err_cnt;
        conv_start();
        finish_conv();
        check("f1_busy_cycles", 32'(busy_cnt), 32'd64);
        shift(6'b100010, 12, "f1_data");
        check("f1_cfg", 32'(cfg_word), 32'h22);
        check("f1_err", 32'(err_cnt - e0), 32'd0);

        // F2: send ch3 unipolar, still reads ch0
        conv_start();
        finish_conv();
        shift(6'b110110, 12, "f2_data");
        check("f2_cfg", 32'(cfg_word), 32'h36);

        // F3: pipelined ch3; send ch5 bipolar
        conv_start();
        finish_conv();
        shift(6'b111000, 12, "f3_data");

        // F4: ch5=000 bipolar; ch_data change after latch has no effect
        conv_start();
        tick(10);
        ch_data[5*12 +: 12] = 12'hFFF;
        finish_conv();
        shift(6'b111000, 12, "f4_data");

        // F5: ch5=FFF bipolar; send differential
        conv_start();
        finish_conv();
        shift(6'b000010, 12, "f5_data");

        // F6: differential -> zero, single error at start
        e0 = err_cnt;
        conv_start();
        finish_conv();
        check("f6_err", 32'(err_cnt - e0), 32'd1);
        check("f6_busy_cycles", 32'(busy_cnt), 32'd64);
        shift(6'b100010, 12, "f6_data");

        // F7: CONVST rise during CONVERT, then extra SCK cycles
        e0 = err_cnt;
        conv_start();
        tick(10);
        bus.ADC_CONVST = 1'b0;
        tick(6);
        bus.ADC_CONVST = 1'b1;
        finish_conv();
        check("f7_busy_cycles", 32'(busy_cnt), 32'd64);
        check("f7_err", 32'(err_cnt - e0), 32'd1);
        shift(6'b100010, 14, "f7_data");
        check("f7_err_after_extra", 32'(err_cnt - e0), 32'd1);

        // F8: reset after six bits of a frame
        conv_start();
        finish_conv();
        shift(6'b111000, 6, "f8_partial");
        check("f8_cfg_before_rst", 32'(cfg_word), 32'h38);
        rst = 1'b1;
        #1;
        check("f8_rst_sdo", 32'(bus.ADC_SDO), 32'h0);
        check("f8_rst_busy", 32'(busy), 32'h0);
        check("f8_rst_cfg", 32'(cfg_word), 32'h22);
        tick(2);
        rst = 1'b0;
        model_cfg = 6'b100010;
        tick(3);

        // F9: normal frame after reset, only 3 config bits sent
        conv_start();
        finish_conv();
        shift(6'b111000, 3, "f9_partial");

        // F10: partial config discarded, still ch0
        conv_start();
        finish_conv();
        shift(6'b100010, 12, "f10_data");

        // F11: CONVST rise in READY discards unread result
        e0 = err_cnt;
        conv_start();
        tick(10);
        bus.ADC_CONVST = 1'b0;
        tick(70);
        void'(exp_q.pop_front());
        ch_data[0*12 +: 12] = 12'h3C3;
        conv_start();
        finish_conv();
        check("f11_err", 32'(err_cnt - e0), 32'd1);
        shift(6'b100010, 12, "f11_data");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
